// File: rtl/alu_regfile_64_pkg.sv
// alu_regfile_64_pkg: shared constants and types for the alu_regfile_64 execution core.
// Holds datapath widths, the 4-bit ALU opcode enum, divider latency and divider FSM states.
// Optional feature macro used by the core: ALU_REGFILE_64_DIV_EN (iterative DIV).
package alu_regfile_64_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned NREGS      = 32;
   localparam int unsigned RADDR_W    = $clog2(NREGS);
   localparam int unsigned SHAMT_W    = $clog2(XLEN);
   localparam int unsigned DIV_CYCLES = 64;
   localparam int unsigned DIV_CNT_W  = $clog2(DIV_CYCLES);

   typedef enum logic [3:0] {
      OpAdd   = 4'b0000,
      OpSub   = 4'b0001,
      OpAnd   = 4'b0010,
      OpOr    = 4'b0011,
      OpXor   = 4'b0100,
      OpNot   = 4'b0101,
      OpShl   = 4'b0110,
      OpMul   = 4'b0111,
      OpShr   = 4'b1000,
      OpSar   = 4'b1001,
      OpDiv   = 4'b1010,
      OpInc   = 4'b1011,
      OpDec   = 4'b1100,
      OpCmp   = 4'b1101,
      OpPassA = 4'b1110,
      OpPassB = 4'b1111
   } aluop_e;

   typedef enum logic {
      DivIdle = 1'b0,
      DivRun  = 1'b1
   } div_state_e;

endpackage

// File: rtl/alu_regfile_64_div.sv
// alu_regfile_64_div: iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 load operands (accepted only while idle)
//   dividend, divisor     XLEN-bit operands
//   busy                  division in progress
//   done                  high in the cycle whose edge completes the division; quotient,
//                         remainder and div_by_zero are valid while done is high
//   quotient, remainder   results (combinational final step)
//   div_by_zero           divisor was zero (quotient all ones, remainder = dividend)
module alu_regfile_64_div
   import alu_regfile_64_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            div_by_zero
);

   div_state_e           state_q, state_d;
   logic [DIV_CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]      rem_q, quo_q, dvs_q;
   logic                 dz_q;

   logic [XLEN:0]        rem_shift;
   logic                 ge;
   logic [XLEN-1:0]      rem_nxt, quo_nxt;
   logic                 last;

   // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
   // while quotient bits enter at the LSB. A zero divisor needs no special path: every
   // step subtracts zero, giving all-ones quotient and remainder = dividend.
   always_comb begin
      rem_shift = {rem_q, quo_q[XLEN-1]};
      ge        = (rem_shift >= {1'b0, dvs_q});
      // True difference is below dvs_q, so modulo-2^XLEN subtraction is exact.
      rem_nxt   = ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];
      quo_nxt   = {quo_q[XLEN-2:0], ge};
      last      = (state_q == DivRun) && (cnt_q == DIV_CNT_W'(DIV_CYCLES - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DivIdle: if (start) state_d = DivRun;
         DivRun:  if (last)  state_d = DivIdle;
         default: state_d = DivIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DivIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         dz_q  <= 1'b0;
      end else if (state_q == DivIdle && start) begin
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         dz_q  <= (divisor == '0);
      end else if (state_q == DivRun) begin
         cnt_q <= cnt_q + 1'b1;
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
      end
   end

   assign busy        = (state_q == DivRun);
   assign done        = last;
   assign quotient    = quo_nxt;
   assign remainder   = rem_nxt;
   assign div_by_zero = dz_q;

endmodule

// File: rtl/alu_regfile_64.sv
// alu_regfile_64: 32 x 64-bit register file feeding a 16-operation ALU with dual results.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data    external register write port
//   start, aluop               issue an operation (ignored while busy)
//   src_a, src_b               operand register addresses
//   dst_lo, dst_hi             writeback addresses (dst_hi only for MUL/DIV)
//   rd_addr, rd_data           combinational observation read port
//   busy                       divide in progress
//   done                       one-cycle completion pulse
//   result, result1            registered ALU outputs
//   cflag, zflag               registered carry/borrow and zero flags
// Macro ALU_REGFILE_64_DIV_EN selects the iterative divider; without it DIV completes in
// one cycle returning zeros with cf = zf = 1 and busy is constantly 0.
module alu_regfile_64
   import alu_regfile_64_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [RADDR_W-1:0] wr_addr,
   input  logic [XLEN-1:0]    wr_data,
   input  logic               start,
   input  logic [3:0]         aluop,
   input  logic [RADDR_W-1:0] src_a,
   input  logic [RADDR_W-1:0] src_b,
   input  logic [RADDR_W-1:0] dst_lo,
   input  logic [RADDR_W-1:0] dst_hi,
   input  logic [RADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]    rd_data,
   output logic               busy,
   output logic               done,
   output logic [XLEN-1:0]    result,
   output logic [XLEN-1:0]    result1,
   output logic               cflag,
   output logic               zflag
);

   logic [XLEN-1:0]    regs_q [NREGS];
   logic [XLEN-1:0]    op_a, op_b;
   logic               issue;

   logic [XLEN:0]      sum, diff, inc, dec;
   logic [2*XLEN-1:0]  prod;

   logic [XLEN-1:0]    alu_lo, alu_hi, alu_prim;
   logic               alu_cf, alu_wlo, alu_whi, alu_is_div;

   logic               cmpl;
   logic [XLEN-1:0]    cmpl_lo, cmpl_hi;
   logic               cmpl_cf, cmpl_zf;
   logic               wb_lo_en, wb_hi_en;
   logic [RADDR_W-1:0] wb_lo_addr, wb_hi_addr;

   logic [XLEN-1:0]    result_q, result1_q;
   logic               cflag_q, zflag_q, done_q;

   assign op_a    = regs_q[src_a];
   assign op_b    = regs_q[src_b];
   assign rd_data = regs_q[rd_addr];
   assign issue   = start & ~busy;

   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};
   assign inc  = {1'b0, op_a} + (XLEN + 1)'(1);
   assign dec  = {1'b0, op_a} - (XLEN + 1)'(1);
   assign prod = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};

   // Single-cycle ALU; bit XLEN of sum/diff/inc/dec is carry or borrow.
   always_comb begin
      alu_lo     = '0;
      alu_hi     = '0;
      alu_cf     = 1'b0;
      alu_wlo    = 1'b1;
      alu_whi    = 1'b0;
      alu_is_div = 1'b0;
      case (aluop)
         OpAdd:   begin alu_lo = sum[XLEN-1:0];  alu_cf = sum[XLEN];  end
         OpSub:   begin alu_lo = diff[XLEN-1:0]; alu_cf = diff[XLEN]; end
         OpAnd:   alu_lo = op_a & op_b;
         OpOr:    alu_lo = op_a | op_b;
         OpXor:   alu_lo = op_a ^ op_b;
         OpNot:   alu_lo = ~op_a;
         OpShl:   alu_lo = op_a << op_b[SHAMT_W-1:0];
         OpShr:   alu_lo = op_a >> op_b[SHAMT_W-1:0];
         OpSar:   alu_lo = XLEN'($signed(op_a) >>> op_b[SHAMT_W-1:0]);
         OpMul:   begin
            alu_lo  = prod[XLEN-1:0];
            alu_hi  = prod[2*XLEN-1:XLEN];
            alu_whi = 1'b1;
         end
         OpDiv:   begin
`ifdef ALU_REGFILE_64_DIV_EN
            // Completion and writeback come from the divider later.
            alu_is_div = 1'b1;
            alu_wlo    = 1'b0;
`else
            alu_cf  = 1'b1;
            alu_whi = 1'b1;
`endif
         end
         OpInc:   begin alu_lo = inc[XLEN-1:0]; alu_cf = inc[XLEN]; end
         OpDec:   begin alu_lo = dec[XLEN-1:0]; alu_cf = dec[XLEN]; end
         OpCmp:   begin alu_cf = diff[XLEN]; alu_wlo = 1'b0; end
         OpPassA: alu_lo = op_a;
         OpPassB: alu_lo = op_b;
         default: alu_lo = '0;
      endcase
      // CMP reports result 0 but flags its difference.
      alu_prim = (aluop == OpCmp) ? diff[XLEN-1:0] : alu_lo;
   end

`ifdef ALU_REGFILE_64_DIV_EN
   logic               div_busy, div_done, div_dz;
   logic [XLEN-1:0]    div_quo, div_rem;
   logic [RADDR_W-1:0] dst_lo_q, dst_hi_q;

   alu_regfile_64_div u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (issue & alu_is_div),
      .dividend    (op_a),
      .divisor     (op_b),
      .busy        (div_busy),
      .done        (div_done),
      .quotient    (div_quo),
      .remainder   (div_rem),
      .div_by_zero (div_dz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_lo_q <= '0;
         dst_hi_q <= '0;
      end else if (issue && alu_is_div) begin
         dst_lo_q <= dst_lo;
         dst_hi_q <= dst_hi;
      end
   end

   assign busy = div_busy;
`else
   assign busy = 1'b0;
`endif

   // Completion source: a single-cycle issue, or the divider finishing. They never
   // coincide because issue is blocked while the divider is busy.
   always_comb begin
      cmpl       = issue & ~alu_is_div;
      cmpl_lo    = alu_lo;
      cmpl_hi    = alu_hi;
      cmpl_cf    = alu_cf;
      cmpl_zf    = (alu_prim == '0);
      wb_lo_en   = cmpl & alu_wlo;
      wb_lo_addr = dst_lo;
      wb_hi_en   = cmpl & alu_whi;
      wb_hi_addr = dst_hi;
`ifdef ALU_REGFILE_64_DIV_EN
      if (div_done) begin
         cmpl       = 1'b1;
         cmpl_lo    = div_quo;
         cmpl_hi    = div_rem;
         cmpl_cf    = div_dz;
         cmpl_zf    = (div_quo == '0);
         wb_lo_en   = 1'b1;
         wb_lo_addr = dst_lo_q;
         wb_hi_en   = 1'b1;
         wb_hi_addr = dst_hi_q;
      end
`endif
   end

   // Later assignments win: ALU writeback beats the external port, hi beats lo.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (wr_en)    regs_q[wr_addr]    <= wr_data;
         if (wb_lo_en) regs_q[wb_lo_addr] <= cmpl_lo;
         if (wb_hi_en) regs_q[wb_hi_addr] <= cmpl_hi;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q    <= 1'b0;
         result_q  <= '0;
         result1_q <= '0;
         cflag_q   <= 1'b0;
         zflag_q   <= 1'b0;
      end else begin
         done_q <= cmpl;
         if (cmpl) begin
            result_q  <= cmpl_lo;
            result1_q <= cmpl_hi;
            cflag_q   <= cmpl_cf;
            zflag_q   <= cmpl_zf;
         end
      end
   end

   assign done    = done_q;
   assign result  = result_q;
   assign result1 = result1_q;
   assign cflag   = cflag_q;
   assign zflag   = zflag_q;

endmodule

// File: tb/tb_alu_regfile_64.sv
// tb_alu_regfile_64: self-checking bench for alu_regfile_64 with directed scenarios and
// randomized operations checked against a behavioural model. Honours ALU_REGFILE_64_DIV_EN.
module tb_alu_regfile_64;

   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_MUL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8, OP_SAR = 4'h9, OP_DIV = 4'hA, OP_INC = 4'hB;
   localparam logic [3:0] OP_DEC = 4'hC, OP_CMP = 4'hD, OP_PA = 4'hE, OP_PB = 4'hF;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        start;
   logic [3:0]  aluop;
   logic [4:0]  src_a, src_b, dst_lo, dst_hi, rd_addr;
   logic [63:0] rd_data;
   logic        busy, done;
   logic [63:0] result, result1;
   logic        cflag, zflag;

   int checks   = 0;
   int failures = 0;

   logic [63:0] m [32];
   logic [63:0] e_res, e_res1;
   logic        e_cf, e_zf;

   always #5 clk = ~clk;

   alu_regfile_64 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .aluop   (aluop),
      .src_a   (src_a),
      .src_b   (src_b),
      .dst_lo  (dst_lo),
      .dst_hi  (dst_hi),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .result1 (result1),
      .cflag   (cflag),
      .zflag   (zflag)
   );

   // Drive one clock of stimulus from a falling edge; returns at the next falling edge.
   task automatic cycle(input logic st, input logic [3:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] lo, input logic [4:0] hi,
                        input logic we, input logic [4:0] waddr, input logic [63:0] wdata);
      start = st; aluop = op; src_a = a; src_b = b; dst_lo = lo; dst_hi = hi;
      wr_en = we; wr_addr = waddr; wr_data = wdata;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic idle();
      cycle(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
   endtask

   task automatic preload(input logic [4:0] addr, input logic [63:0] data);
      cycle(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, addr, data);
      m[addr] = data;
   endtask

   task automatic read_reg(input logic [4:0] addr, output logic [63:0] data);
      rd_addr = addr;
      #1;
      data = rd_data;
   endtask

   task automatic wait_not_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         idle();
      end
   endtask

   // Reference semantics of one operation on operand values a, b.
   task automatic model_exec(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] lo, output logic [63:0] hi, output logic cf,
                             output logic zf, output logic wlo, output logic whi);
      logic [127:0] p;
      int unsigned  s;
      lo = 64'd0; hi = 64'd0; cf = 1'b0; wlo = 1'b1; whi = 1'b0;
      s = 32'(b % 64);
      case (op)
         OP_ADD: begin lo = a + b; cf = (lo < a); end
         OP_SUB: begin lo = a - b; cf = (a < b); end
         OP_AND: lo = a & b;
         OP_OR:  lo = a | b;
         OP_XOR: lo = a ^ b;
         OP_NOT: lo = ~a;
         OP_SHL: lo = a << s;
         OP_SHR: lo = a >> s;
         OP_SAR: lo = (a >> s) | (a[63] ? ~(ONES >> s) : 64'd0);
         OP_MUL: begin p = 128'(a) * 128'(b); lo = p[63:0]; hi = p[127:64]; whi = 1'b1; end
         OP_DIV: begin
`ifdef ALU_REGFILE_64_DIV_EN
            if (b == 64'd0) begin lo = ONES; hi = a; cf = 1'b1; end
            else begin lo = a / b; hi = a % b; end
`else
            cf = 1'b1;
`endif
            whi = 1'b1;
         end
         OP_INC: begin lo = a + 64'd1; cf = (a == ONES); end
         OP_DEC: begin lo = a - 64'd1; cf = (a == 64'd0); end
         OP_CMP: begin cf = (a < b); wlo = 1'b0; end
         OP_PA:  lo = a;
         default: lo = b;
      endcase
      zf = (op == OP_CMP) ? (a == b) : (lo == 64'd0);
   endtask

   // Update model registers and expected outputs for an issue (writes take effect together).
   task automatic model_issue(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] lo, input logic [4:0] hi, input logic we,
                              input logic [4:0] waddr, input logic [63:0] wdata);
      logic [63:0] r0, r1;
      logic        c, z, wl, wh;
      model_exec(op, m[a], m[b], r0, r1, c, z, wl, wh);
      if (we) m[waddr] = wdata;
      if (wl) m[lo] = r0;
      if (wh) m[hi] = r1;
      e_res = r0; e_res1 = r1; e_cf = c; e_zf = z;
   endtask

   task automatic test_reset();
      logic [63:0] v;
      rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; aluop = 4'd0; src_a = 5'd0; src_b = 5'd0;
      dst_lo = 5'd0; dst_hi = 5'd0; wr_addr = 5'd0; wr_data = 64'd0; rd_addr = 5'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) m[i] = 64'd0;
      idle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
      checks++; if (result1 !== 64'd0) begin failures++; $display("FAIL reset_result1: got %h expected 0", result1); end
      checks++; if (cflag !== 1'b0 || zflag !== 1'b0) begin failures++; $display("FAIL reset_flags: got c=%b z=%b expected 0 0", cflag, zflag); end
      for (int i = 0; i < 32; i++) begin
         read_reg(5'(i), v);
         checks++; if (v !== 64'd0) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
      end
      @(negedge clk);
   endtask

   task automatic test_add_carry();
      logic [63:0] v;
      preload(5'd1, ONES);
      preload(5'd2, 64'd1);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_pre_done: got %b expected 0", done); end
      cycle(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 5'd0, 64'd0);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done: got %b expected 1", done); end
      checks++; if (result !== 64'd0 || result1 !== 64'd0) begin failures++; $display("FAIL add_result: got %h/%h expected 0/0", result, result1); end
      checks++; if (cflag !== 1'b1 || zflag !== 1'b1) begin failures++; $display("FAIL add_flags: got c=%b z=%b expected 1 1", cflag, zflag); end
      read_reg(5'd3, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL add_reg3: got %h expected 0", v); end
      idle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b expected 0", done); end
      checks++; if (cflag !== 1'b1 || zflag !== 1'b1) begin failures++; $display("FAIL add_flags_hold: got c=%b z=%b expected 1 1", cflag, zflag); end
   endtask

   task automatic test_mul();
      logic [63:0] v;
      preload(5'd1, 64'h1_0000_0000);
      preload(5'd2, 64'h1_0000_0000);
      cycle(1'b1, OP_MUL, 5'd1, 5'd2, 5'd4, 5'd5, 1'b0, 5'd0, 64'd0);
      checks++; if (done !== 1'b1 || result !== 64'd0 || result1 !== 64'd1) begin failures++; $display("FAIL mul_result: got done=%b %h/%h expected 1 0/1", done, result, result1); end
      checks++; if (zflag !== 1'b1 || cflag !== 1'b0) begin failures++; $display("FAIL mul_flags: got c=%b z=%b expected 0 1", cflag, zflag); end
      read_reg(5'd4, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL mul_reg4: got %h expected 0", v); end
      read_reg(5'd5, v);
      checks++; if (v !== 64'd1) begin failures++; $display("FAIL mul_reg5: got %h expected 1", v); end
   endtask

   task automatic test_div();
      logic [63:0] v;
      int          n;
      logic        early;
      preload(5'd1, 64'd100);
      preload(5'd2, 64'd7);
      preload(5'd8, 64'h55);
      cycle(1'b1, OP_DIV, 5'd1, 5'd2, 5'd6, 5'd7, 1'b0, 5'd0, 64'd0);
`ifdef ALU_REGFILE_64_DIV_EN
      n = 0; early = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (done === 1'b1) early = 1'b1;
         // A start while busy must be dropped.
         if (n == 10) cycle(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8, 5'd0, 1'b0, 5'd0, 64'd0);
         else idle();
      end
      checks++; if (n !== 64) begin failures++; $display("FAIL div_busy_cycles: got %0d expected 64", n); end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL div_early_done: got %b expected 0", early); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL div_done: got %b expected 1", done); end
      checks++; if (result !== 64'd14 || result1 !== 64'd2) begin failures++; $display("FAIL div_result: got %h/%h expected e/2", result, result1); end
      checks++; if (cflag !== 1'b0 || zflag !== 1'b0) begin failures++; $display("FAIL div_flags: got c=%b z=%b expected 0 0", cflag, zflag); end
      read_reg(5'd6, v);
      checks++; if (v !== 64'd14) begin failures++; $display("FAIL div_reg6: got %h expected e", v); end
      read_reg(5'd7, v);
      checks++; if (v !== 64'd2) begin failures++; $display("FAIL div_reg7: got %h expected 2", v); end
      read_reg(5'd8, v);
      checks++; if (v !== 64'h55) begin failures++; $display("FAIL div_ignored_start: got %h expected 55", v); end
      idle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL div_done_pulse: got %b expected 0", done); end
`else
      n = 0; early = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b1 || result !== 64'd0 || result1 !== 64'd0) begin failures++; $display("FAIL div_result: got done=%b %h/%h expected 1 0/0", done, result, result1); end
      checks++; if (cflag !== 1'b1 || zflag !== 1'b1) begin failures++; $display("FAIL div_flags: got c=%b z=%b expected 1 1", cflag, zflag); end
      read_reg(5'd6, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL div_reg6: got %h expected 0", v); end
      read_reg(5'd7, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL div_reg7: got %h expected 0", v); end
      @(negedge clk);
`endif
   endtask

   task automatic test_div_zero();
      logic [63:0] v;
      int          n;
      preload(5'd1, 64'd5);
      preload(5'd2, 64'd0);
      cycle(1'b1, OP_DIV, 5'd1, 5'd2, 5'd9, 5'd10, 1'b0, 5'd0, 64'd0);
`ifdef ALU_REGFILE_64_DIV_EN
      wait_not_busy(n);
      checks++; if (n !== 64) begin failures++; $display("FAIL divz_cycles: got %0d expected 64", n); end
      checks++; if (done !== 1'b1 || result !== ONES || result1 !== 64'd5) begin failures++; $display("FAIL divz_result: got done=%b %h/%h expected 1 ffffffffffffffff/5", done, result, result1); end
      checks++; if (cflag !== 1'b1 || zflag !== 1'b0) begin failures++; $display("FAIL divz_flags: got c=%b z=%b expected 1 0", cflag, zflag); end
      read_reg(5'd9, v);
      checks++; if (v !== ONES) begin failures++; $display("FAIL divz_reg9: got %h expected all ones", v); end
      read_reg(5'd10, v);
      checks++; if (v !== 64'd5) begin failures++; $display("FAIL divz_reg10: got %h expected 5", v); end
`else
      n = 0;
      checks++; if (done !== 1'b1 || result !== 64'd0 || cflag !== 1'b1 || zflag !== 1'b1) begin failures++; $display("FAIL divz_result: got done=%b %h c=%b z=%b expected 1 0 1 1", done, result, cflag, zflag); end
`endif
      @(negedge clk);
   endtask

   task automatic test_cmp_collision();
      logic [63:0] v;
      preload(5'd1, 64'd9);
      preload(5'd2, 64'd9);
      preload(5'd11, 64'h1234);
      cycle(1'b1, OP_CMP, 5'd1, 5'd2, 5'd11, 5'd0, 1'b0, 5'd0, 64'd0);
      checks++; if (done !== 1'b1 || zflag !== 1'b1 || cflag !== 1'b0) begin failures++; $display("FAIL cmp_flags: got done=%b c=%b z=%b expected 1 0 1", done, cflag, zflag); end
      checks++; if (result !== 64'd0 || result1 !== 64'd0) begin failures++; $display("FAIL cmp_result: got %h/%h expected 0/0", result, result1); end
      read_reg(5'd11, v);
      checks++; if (v !== 64'h1234) begin failures++; $display("FAIL cmp_no_wb: got %h expected 1234", v); end
      preload(5'd12, 64'd3);
      preload(5'd13, 64'd4);
      cycle(1'b1, OP_ADD, 5'd12, 5'd13, 5'd14, 5'd0, 1'b1, 5'd14, 64'hDEAD);
      read_reg(5'd14, v);
      checks++; if (v !== 64'd7) begin failures++; $display("FAIL collide_alu_wins: got %h expected 7", v); end
      cycle(1'b1, OP_ADD, 5'd12, 5'd13, 5'd15, 5'd0, 1'b1, 5'd16, 64'hBEEF);
      read_reg(5'd15, v);
      checks++; if (v !== 64'd7) begin failures++; $display("FAIL both_alu: got %h expected 7", v); end
      read_reg(5'd16, v);
      checks++; if (v !== 64'hBEEF) begin failures++; $display("FAIL both_ext: got %h expected beef", v); end
      preload(5'd18, 64'h8000_0000_0000_0001);
      preload(5'd19, 64'd6);
      cycle(1'b1, OP_MUL, 5'd18, 5'd19, 5'd17, 5'd17, 1'b0, 5'd0, 64'd0);
      read_reg(5'd17, v);
      checks++; if (v !== 64'd3) begin failures++; $display("FAIL hi_wins_same_dst: got %h expected 3", v); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] v;
      logic [3:0]  ops [4];
      logic [4:0]  sa [4], sb [4], sd [4];
      ops = '{OP_ADD, OP_ADD, OP_SUB, OP_MUL};
      sa  = '{5'd20, 5'd22, 5'd23, 5'd24};
      sb  = '{5'd21, 5'd22, 5'd20, 5'd23};
      sd  = '{5'd22, 5'd23, 5'd24, 5'd25};
      preload(5'd20, 64'd1);
      preload(5'd21, 64'd1);
      for (int i = 0; i < 4; i++) begin
         model_issue(ops[i], sa[i], sb[i], sd[i], 5'd26, 1'b0, 5'd0, 64'd0);
         cycle(1'b1, ops[i], sa[i], sb[i], sd[i], 5'd26, 1'b0, 5'd0, 64'd0);
         checks++; if (done !== 1'b1 || result !== e_res) begin failures++; $display("FAIL b2b_%0d: got done=%b %h expected 1 %h", i, done, result, e_res); end
      end
      read_reg(5'd25, v);
      checks++; if (v !== 64'd12) begin failures++; $display("FAIL b2b_chain: got %h expected c", v); end
   endtask

   task automatic test_random();
      logic [63:0] v;
      logic [3:0]  op;
      logic [4:0]  a, b, lo, hi, waddr;
      logic        we;
      logic [63:0] wdata;
      int          n;
      for (int i = 0; i < 32; i++) begin
         case (i % 8)
            0: v = 64'd0;
            1: v = ONES;
            2: v = 64'($urandom_range(0, 20));
            3: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, $urandom};
         endcase
         preload(5'(i), v);
      end
      for (int it = 0; it < 300; it++) begin
         op    = 4'($urandom_range(0, 15));
         a     = 5'($urandom); b = 5'($urandom); lo = 5'($urandom);
         hi    = ($urandom_range(0, 3) == 0) ? lo : 5'($urandom);
         we    = 1'($urandom);
         waddr = ($urandom_range(0, 2) == 0) ? lo : 5'($urandom);
         wdata = {$urandom, $urandom};
         model_issue(op, a, b, lo, hi, we, waddr, wdata);
         cycle(1'b1, op, a, b, lo, hi, we, waddr, wdata);
`ifdef ALU_REGFILE_64_DIV_EN
         if (op == OP_DIV) begin
            wait_not_busy(n);
            checks++; if (n !== 64) begin failures++; $display("FAIL rand_div_cycles: got %0d expected 64", n); end
         end
`endif
         checks++; if (done !== 1'b1) begin failures++; $display("FAIL rand_done op=%0d: got %b expected 1", op, done); end
         checks++; if (result !== e_res || result1 !== e_res1) begin failures++; $display("FAIL rand_result op=%0d: got %h/%h expected %h/%h", op, result, result1, e_res, e_res1); end
         checks++; if (cflag !== e_cf || zflag !== e_zf) begin failures++; $display("FAIL rand_flags op=%0d: got c=%b z=%b expected %b %b", op, cflag, zflag, e_cf, e_zf); end
         read_reg(lo, v);
         checks++; if (v !== m[lo]) begin failures++; $display("FAIL rand_reg_lo op=%0d r%0d: got %h expected %h", op, lo, v, m[lo]); end
         read_reg(hi, v);
         checks++; if (v !== m[hi]) begin failures++; $display("FAIL rand_reg_hi op=%0d r%0d: got %h expected %h", op, hi, v, m[hi]); end
         read_reg(waddr, v);
         checks++; if (v !== m[waddr]) begin failures++; $display("FAIL rand_reg_wr op=%0d r%0d: got %h expected %h", op, waddr, v, m[waddr]); end
         if ($urandom_range(0, 7) == 0) begin
            idle();
            checks++; if (done !== 1'b0 || result !== e_res || zflag !== e_zf) begin failures++; $display("FAIL rand_hold: got done=%b %h z=%b expected 0 %h %b", done, result, zflag, e_res, e_zf); end
         end
      end
      for (int i = 0; i < 32; i++) begin
         read_reg(5'(i), v);
         checks++; if (v !== m[i]) begin failures++; $display("FAIL rand_sweep r%0d: got %h expected %h", i, v, m[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      logic [63:0] v;
      preload(5'd1, 64'd100);
      preload(5'd2, 64'd7);
      preload(5'd27, 64'h77);
`ifdef ALU_REGFILE_64_DIV_EN
      cycle(1'b1, OP_DIV, 5'd1, 5'd2, 5'd27, 5'd28, 1'b0, 5'd0, 64'd0);
      repeat (20) idle();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstdiv_busy_before: got %b expected 1", busy); end
`else
      cycle(1'b1, OP_ADD, 5'd1, 5'd2, 5'd28, 5'd0, 1'b0, 5'd0, 64'd0);
`endif
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstdiv_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
      checks++; if (result !== 64'd0 || result1 !== 64'd0 || cflag !== 1'b0 || zflag !== 1'b0) begin failures++; $display("FAIL rstdiv_outputs: got %h/%h c=%b z=%b expected all 0", result, result1, cflag, zflag); end
      for (int i = 0; i < 32; i++) begin
         read_reg(5'(i), v);
         checks++; if (v !== 64'd0) begin failures++; $display("FAIL rstdiv_reg%0d: got %h expected 0", i, v); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) m[i] = 64'd0;
      repeat (70) idle();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstdiv_no_resume: got busy=%b done=%b expected 0 0", busy, done); end
      read_reg(5'd27, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL rstdiv_no_wb: got %h expected 0", v); end
      read_reg(5'd28, v);
      checks++; if (v !== 64'd0) begin failures++; $display("FAIL rstdiv_no_wb_hi: got %h expected 0", v); end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_mul();
      test_div();
      test_div_zero();
      test_cmp_collision();
      test_back_to_back();
      test_random();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_regfile_64.md
# alu_regfile_64

64-bit execution core for one processor core of the quad-core design: a 32 x 64-bit register file feeding a 16-operation ALU with dual 64-bit results and carry/zero flags. The core issues one ALU operation at a time from register-addressed operands and writes the results back into the register file. An external load port preloads registers, and an observation read port exposes register contents.

## Interface
- No parameters. Widths are fixed: XLEN=64, NREGS=32.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- wr_en  in  1  external register write strobe
- wr_addr  in  5  external write address
- wr_data  in  64  external write data
- start  in  1  issue an operation; sampled only when busy=0
- aluop  in  4  operation code
- src_a, src_b  in  5 each  operand register addresses
- dst_lo  in  5  destination of result
- dst_hi  in  5  destination of result1; used only by MUL and DIV
- rd_addr  in  5  observation read address
- rd_data  out  64  combinational register contents at rd_addr
- busy  out  1  a divide is in progress
- done  out  1  one-cycle pulse when results are valid
- result, result1  out  64 each  registered ALU outputs
- cflag, zflag  out  1 each  registered flags

## Operation
- aluop encoding (A = reg[src_a], B = reg[src_b]):
  - 0000 ADD; cf = carry out.
  - 0001 SUB, A-B; cf = borrow.
  - 0010 AND; 0011 OR; 0100 XOR; 0101 NOT A.
  - 0110 SHL A by B[5:0]; 1000 SHR logical; 1001 SAR.
  - 0111 MUL unsigned: result = product[63:0], result1 = product[127:64].
  - 1010 DIV unsigned: result = quotient, result1 = remainder.
  - 1011 INC A; 1100 DEC A.
  - 1101 CMP: A-B sets flags only; result = 0, no writeback.
  - 1110 PASS A; 1111 PASS B.
- result1 = 0 for every op except MUL and DIV.
- cf = 0 for every op except ADD, SUB, INC, DEC, CMP and DIV-by-zero.
- zflag = (ALU primary value == 0). For CMP the primary value is A-B.
- DIV by zero: quotient = all ones, remainder = A, cf = 1.
- Writeback:
  - result goes to dst_lo, except for CMP.
  - MUL and DIV also write result1 to dst_hi.
  - If dst_lo == dst_hi, the result1 (hi) value is the one stored.
- Register 0 is an ordinary register, not hardwired to zero.
- External write and ALU writeback to the same address on the same edge: ALU writeback wins. Otherwise both take effect.
- Operands are read from pre-edge register contents. A same-edge external write is not forwarded.
- start while busy=1 is ignored; no queuing.

## Timing
- Reset clears all registers, result, result1, cflag, zflag, done and busy to 0 immediately. Reset asserted mid-divide aborts the divide with no writeback.
- Non-DIV ops, start sampled at edge N:
  - Operands are read, computed and registered at edge N.
  - Writeback happens at edge N.
  - done = 1 for the cycle after edge N.
  - Back-to-back issue every cycle is allowed and sees the prior writeback.
- DIV, start sampled at edge N:
  - Operands are latched at edge N; busy = 1 from N.
  - Iterative restoring divider, 1 bit per cycle.
  - Results, flags and writeback at edge N+64.
  - busy falls and done pulses in the following cycle.
- result, result1 and the flags hold their value until the next completion.

## Configuration
- ALU_REGFILE_64_DIV_EN defined: DIV is implemented as specified above.
- Undefined: aluop 1010 completes in a single cycle with result = result1 = 0, cf = 1, zf = 1, and writeback of zeros. busy is then constantly 0.

## Structure
- Package alu_regfile_64_pkg holds:
  - XLEN, NREGS and address-width constants.
  - aluop code localparams or enum.
  - DIV_CYCLES = 64.
- Sub-module alu_regfile_64_div is the iterative unsigned divider, with start/done handshake, quotient and remainder outputs, and divide-by-zero handling.
- The register file and combinational ALU live in the top module.

## Test plan
- Preload reg1 = 0xFFFF_FFFF_FFFF_FFFF and reg2 = 1, then ADD into reg3 -> reg3 = 0, cf = 1, zf = 1, done one cycle later.
- reg1 = 0x1_0000_0000 and reg2 = 0x1_0000_0000, MUL with dst_lo = 4, dst_hi = 5 -> reg4 = 0, reg5 = 1, zf = 1.
- reg1 = 100 and reg2 = 7, DIV -> busy for 64 cycles, quotient 14, remainder 2; a start issued while busy is ignored.
- DIV of 5 by 0 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, cf = 1.
- CMP with reg1 = reg2 = 9 -> zf = 1, cf = 0, dst_lo unchanged. External write to dst_lo on the same edge as an ADD writeback -> the ADD value is stored.
- Assert rst_n mid-divide -> all outputs 0, rd_data of any address = 0, busy = 0.
